// File: rtl/flog_pkg.sv
// flog_pkg: shared defaults, FSM states, flag indices and
// special-value helpers for the floating-point log2 core.
package flog_pkg;

  localparam int EXP_W_D     = 8;
  localparam int FRACT_W_D   = 7;
  localparam int LOG_BITS_D  = 12;
  localparam int MANT_PREC_D = 16;

  localparam int FLAG_INV = 0;
  localparam int FLAG_DZ  = 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    NORM,
    OUT
  } state_t;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic logic [31:0] emax(input int ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

  function automatic logic [31:0] nan_fract(input int fw);
    return 32'd1 << (fw - 1);
  endfunction

  function automatic logic [31:0] inf_fract();
    return 32'd0;
  endfunction

endpackage

// File: rtl/flog_mant_iter.sv
// flog_mant_iter: repeated-squaring log2 of a [1,2) mantissa,
// one result bit per cycle, MSB first.
module flog_mant_iter
  import flog_pkg::*;
#(
  parameter int FRACT_WIDTH = FRACT_W_D,
  parameter int LOG_BITS    = LOG_BITS_D,
  parameter int MANT_PREC   = MANT_PREC_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [FRACT_WIDTH-1:0] i_fract,
  output logic                   o_done,
  output logic [LOG_BITS-1:0]    o_logfrac
);

  localparam int MW = MANT_PREC + 1;
  localparam int CW = $clog2(LOG_BITS + 1);

  logic [MW-1:0]       r_m;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic [LOG_BITS-1:0] r_lf;

  logic [2*MW-1:0] w_prod;
  logic [MW:0]     w_sq;
  logic            w_bit;
  logic [MW-1:0]   w_mnext;

  // m holds 1 integer bit and MANT_PREC fraction bits
  assign w_prod  = {{MW{1'b0}}, r_m} * {{MW{1'b0}}, r_m};
  assign w_sq    = (MW + 1)'(w_prod >> MANT_PREC);
  assign w_bit   = w_sq[MW];
  assign w_mnext = w_bit ? w_sq[MW:1] : w_sq[MW-1:0];

  assign o_done    = r_busy && (r_cnt == CW'(LOG_BITS - 1));
  assign o_logfrac = r_lf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_lf   <= '0;
    end else if (i_start) begin
      r_m    <= {1'b1, i_fract,
                 {(MANT_PREC - FRACT_WIDTH){1'b0}}};
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_lf   <= '0;
    end else if (r_busy) begin
      r_m   <= w_mnext;
      r_lf  <= {r_lf[LOG_BITS-2:0], w_bit};
      r_cnt <= r_cnt + 1'b1;
      if (o_done)
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/flog_bf_core.sv
// flog_bf_core: parametrised float log2 with valid/ready on both
// sides. Define FLOG_RNE_EN for round-to-nearest-even results.
module flog_bf_core
  import flog_pkg::*;
#(
  parameter int EXP_WIDTH   = EXP_W_D,
  parameter int FRACT_WIDTH = FRACT_W_D,
  parameter int LOG_BITS    = LOG_BITS_D,
  parameter int MANT_PREC   = MANT_PREC_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sign_i,
  input  logic [EXP_WIDTH-1:0]   exp_i,
  input  logic [FRACT_WIDTH-1:0] fract_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   s_res_o,
  output logic [EXP_WIDTH-1:0]   e_res_o,
  output logic [FRACT_WIDTH-1:0] f_res_o,
  output logic [1:0]             flags_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int VW = EXP_WIDTH + 1 + LOG_BITS;
  localparam int PW = $clog2(VW);
  localparam logic [EXP_WIDTH-1:0] EMAX =
    EXP_WIDTH'(emax(EXP_WIDTH));
  localparam logic [EXP_WIDTH-1:0] BIASV =
    EXP_WIDTH'(bias(EXP_WIDTH));
  localparam logic [FRACT_WIDTH-1:0] QNAN_F =
    FRACT_WIDTH'(nan_fract(FRACT_WIDTH));
  localparam logic [FRACT_WIDTH-1:0] INF_F =
    FRACT_WIDTH'(inf_fract());

  state_t r_state, w_nstate;

  logic [EXP_WIDTH:0]     r_k;
  logic                   r_s;
  logic [EXP_WIDTH-1:0]   r_e;
  logic [FRACT_WIDTH-1:0] r_f;
  logic [1:0]             r_flags;

  logic                   w_accept;
  logic                   w_done;
  logic [LOG_BITS-1:0]    w_logfrac;

  logic                   w_spec;
  logic                   w_cs;
  logic [EXP_WIDTH-1:0]   w_ce;
  logic [FRACT_WIDTH-1:0] w_cf;
  logic [1:0]             w_cfl;
  logic                   w_zero, w_nan, w_neg, w_pinf;

  logic [VW-1:0]          w_v, w_mag;
  logic [PW-1:0]          w_p;
  logic                   w_ns;
  logic [EXP_WIDTH-1:0]   w_ne;
  logic [FRACT_WIDTH-1:0] w_nf;

  assign w_accept = valid_i && (r_state == IDLE);
  assign ready_o  = (r_state == IDLE);
  assign valid_o  = (r_state == OUT);
  assign s_res_o  = r_s;
  assign e_res_o  = r_e;
  assign f_res_o  = r_f;
  assign flags_o  = r_flags;

  assign w_zero = (exp_i == '0);
  assign w_nan  = (exp_i == EMAX) && (fract_i != '0);
  assign w_neg  = sign_i && !w_zero && !w_nan;
  assign w_pinf = !sign_i && (exp_i == EMAX) &&
                  (fract_i == '0);

  always_comb begin
    w_spec = 1'b1;
    w_cs   = 1'b0;
    w_ce   = EMAX;
    w_cf   = INF_F;
    w_cfl  = '0;
    unique case (1'b1)
      w_zero: begin
        w_cs           = 1'b1;
        w_cfl[FLAG_DZ] = 1'b1;
      end
      w_nan:  w_cf = QNAN_F;
      w_neg: begin
        w_cf            = QNAN_F;
        w_cfl[FLAG_INV] = 1'b1;
      end
      w_pinf: w_cf = INF_F;
      default: w_spec = 1'b0;
    endcase
  end

  flog_mant_iter #(
    .FRACT_WIDTH (FRACT_WIDTH),
    .LOG_BITS    (LOG_BITS),
    .MANT_PREC   (MANT_PREC)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && !w_spec),
    .i_fract   (fract_i),
    .o_done    (w_done),
    .o_logfrac (w_logfrac)
  );

  assign w_v   = {r_k, w_logfrac};
  assign w_mag = w_v[VW-1] ? (~w_v + 1'b1) : w_v;

`ifdef FLOG_RNE_EN
  localparam int SW = VW + FRACT_WIDTH + 1;
  logic [SW-1:0]        w_ext;
  logic                 w_g, w_st;
  logic [FRACT_WIDTH:0] w_rf;
`endif

  always_comb begin
    w_p = '0;
    for (int i = 0; i < VW; i++)
      if (w_mag[i]) w_p = PW'(i);
    w_ns = w_v[VW-1];
    w_ne = EXP_WIDTH'(w_p) - EXP_WIDTH'(LOG_BITS) + BIASV;
`ifdef FLOG_RNE_EN
    // leading one shifted out; f, guard, sticky remain
    w_ext = SW'({w_mag, {(FRACT_WIDTH + 2){1'b0}}}
                << (VW - 1 - int'(w_p)));
    w_nf  = w_ext[SW-1 -: FRACT_WIDTH];
    w_g   = w_ext[SW-1-FRACT_WIDTH];
    w_st  = |w_ext[SW-2-FRACT_WIDTH:0];
    w_rf  = {1'b0, w_nf} +
            (FRACT_WIDTH + 1)'(w_g && (w_st || w_nf[0]));
    w_nf  = w_rf[FRACT_WIDTH-1:0];
    if (w_rf[FRACT_WIDTH])
      w_ne = w_ne + 1'b1;
    if (w_ne == EMAX)
      w_nf = '0;
`else
    w_nf = FRACT_WIDTH'(({w_mag, {FRACT_WIDTH{1'b0}}}
             << (VW - 1 - int'(w_p))) >> (VW - 1));
`endif
    if (w_mag == '0) begin
      w_ns = 1'b0;
      w_ne = '0;
      w_nf = '0;
    end
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_nstate = w_spec ? OUT : ITER;
      ITER: if (w_done) w_nstate = NORM;
      NORM: w_nstate = OUT;
      OUT:  if (ready_i) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nstate;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k     <= '0;
      r_s     <= 1'b0;
      r_e     <= '0;
      r_f     <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_k <= {1'b0, exp_i} - {1'b0, BIASV};
      if (w_spec) begin
        r_s     <= w_cs;
        r_e     <= w_ce;
        r_f     <= w_cf;
        r_flags <= w_cfl;
      end
    end else if (r_state == NORM) begin
      r_s     <= w_ns;
      r_e     <= w_ne;
      r_f     <= w_nf;
      r_flags <= '0;
    end
  end

endmodule

// File: tb/tb_flog_bf_core.sv
// tb_flog_bf_core: directed vector table plus backpressure
// and mid-operation reset sequences for flog_bf_core.
module tb_flog_bf_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sign_i = 1'b0;
  logic [7:0] exp_i = '0;
  logic [6:0] fract_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;
  logic       ready_o, s_res_o, valid_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic [1:0] flags_o;

  int errs = 0;
  int checks = 0;

  flog_bf_core dut (
    .clk     (clk),
    .rst     (rst),
    .sign_i  (sign_i),
    .exp_i   (exp_i),
    .fract_i (fract_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .s_res_o (s_res_o),
    .e_res_o (e_res_o),
    .f_res_o (f_res_o),
    .flags_o (flags_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] op;
    logic [15:0] res;
    logic [1:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] op,
                        output logic [15:0] res,
                        output logic [1:0] fl,
                        output int lat);
    @(negedge clk);
    {sign_i, exp_i, fract_i} = op;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    {sign_i, exp_i, fract_i} = 16'($urandom);
    wait_valid(lat);
    res = {s_res_o, e_res_o, f_res_o};
    fl  = flags_o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] res, r0;
    logic [1:0]  fl;
    int          lat;

    vecs[0]  = '{16'h4000, 16'h3F80, 2'b00, 14};
    vecs[1]  = '{16'h3F80, 16'h0000, 2'b00, 14};
    vecs[2]  = '{16'h3F00, 16'hBF80, 2'b00, 14};
    vecs[3]  = '{16'h4100, 16'h4040, 2'b00, 14};
`ifdef FLOG_RNE_EN
    vecs[4]  = '{16'h3FC0, 16'h3F16, 2'b00, 14};
`else
    vecs[4]  = '{16'h3FC0, 16'h3F15, 2'b00, 14};
`endif
    vecs[5]  = '{16'h0000, 16'hFF80, 2'b10, 1};
    vecs[6]  = '{16'hBF80, 16'h7FC0, 2'b01, 1};
    vecs[7]  = '{16'h7F80, 16'h7F80, 2'b00, 1};
    vecs[8]  = '{16'h8000, 16'hFF80, 2'b10, 1};
    vecs[9]  = '{16'h7FC1, 16'h7FC0, 2'b00, 1};
    vecs[10] = '{16'hFF80, 16'h7FC0, 2'b01, 1};
    vecs[11] = '{16'h3E80, 16'hC000, 2'b00, 14};

    #2;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_res", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
    chk("rst_flags", 32'(flags_o), 32'd0);
    #5 rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, res, fl, lat);
      chk($sformatf("res_%h", vecs[i].op), 32'(res),
          32'(vecs[i].res));
      chk($sformatf("flags_%h", vecs[i].op), 32'(fl),
          32'(vecs[i].fl));
      chk($sformatf("lat_%h", vecs[i].op), 32'(lat),
          32'(vecs[i].lat));
    end

    // backpressure: result held, second operand waits
    ready_i = 1'b0;
    @(negedge clk);
    {sign_i, exp_i, fract_i} = 16'h4000;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    {sign_i, exp_i, fract_i} = 16'h4100;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd14);
    r0 = {s_res_o, e_res_o, f_res_o};
    chk("bp_res", 32'(r0), 32'h3F80);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_ready", 32'(ready_o), 32'd0);
      chk("bp_stable", 32'({s_res_o, e_res_o, f_res_o}),
          32'(r0));
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", 32'(valid_o), 32'd0);
    chk("hs_ready", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("second_taken", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    wait_valid(lat);
    chk("second_lat", 32'(lat), 32'd14);
    chk("second_res", 32'({s_res_o, e_res_o, f_res_o}),
        32'h4040);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of ITER
    @(negedge clk);
    {sign_i, exp_i, fract_i} = 16'h4000;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_res", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
    chk("arst_flags", 32'(flags_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      chk("arst_no_result", 32'(valid_o), 32'd0);
    end
    run_op(16'h4000, res, fl, lat);
    chk("post_rst_res", 32'(res), 32'h3F80);
    chk("post_rst_lat", 32'(lat), 32'd14);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/flog_bf_core.md
Name: flog_bf_core

Overview:
- Parametrised floating-point log2 unit: takes one IEEE-style operand (sign/exponent/fraction, bfloat16 by default) and returns log2 of it in the same format.
- Successor to the fixed-width bfloat16 log top. Adds generic EXP_WIDTH/FRACT_WIDTH, configurable log precision, valid/ready handshake on both sides with output backpressure, and IEEE special-case handling with exception flags.
- Sits between the operand register stage and the result writeback of the log datapath.

Parameters:
- EXP_WIDTH, 8, exponent field width
- FRACT_WIDTH, 7, stored fraction width (hidden bit excluded)
- LOG_BITS, 12, fractional bits of log2(mantissa) produced; one bit per iteration
- MANT_PREC, 16, internal mantissa precision for squaring (must be > FRACT_WIDTH+1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- sign_i  in  1  operand sign
- exp_i  in  EXP_WIDTH  biased operand exponent
- fract_i  in  FRACT_WIDTH  operand fraction
- valid_i  in  1  operand valid
- ready_o  out  1  block can accept an operand
- s_res_o  out  1  result sign
- e_res_o  out  EXP_WIDTH  result biased exponent
- f_res_o  out  FRACT_WIDTH  result fraction
- flags_o  out  2  [0] invalid, [1] divide-by-zero
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result

Behaviour:
- Reset (rst low, asynchronous): state IDLE, ready_o=1, valid_o=0, all result outputs and flags_o 0. Reset mid-operation aborts it; no result is emitted.
- BIAS = 2^(EXP_WIDTH-1)-1. EMAX is all ones.
- IDLE: ready_o=1. On valid_i&&ready_o, latch the operand and classify it.
  - exp=0 (zero or denormal; denormals flushed) -> -inf (s=1, e=EMAX, f=0), flag divzero.
  - sign=1, nonzero non-NaN -> canonical NaN (s=0, e=EMAX, f=1<<(FRACT_WIDTH-1)), flag invalid.
  - exp=EMAX, f!=0 -> canonical NaN, no flag.
  - +inf -> +inf, no flag.
  - Special cases go to OUT. Normal operands: k = exp-BIAS (signed, EXP_WIDTH+1 bits), m = 1.fract zero-extended to MANT_PREC, go to ITER.
- ITER: LOG_BITS cycles, iteration counter.
  - Each cycle: sq = m*m truncated to MANT_PREC fractional bits.
  - If sq >= 2: emit bit 1, m = sq>>1. Otherwise emit bit 0, m = sq.
  - Bits fill the log fraction MSB first. After the last bit, go to NORM.
- NORM (1 cycle):
  - v = {k, logfrac}, signed fixed point (EXP_WIDTH+1).LOG_BITS.
  - s = v<0. mag = |v|. If mag=0, result is +0.
  - Otherwise p = leading-one index. e = p - LOG_BITS + BIAS. f = the FRACT_WIDTH bits below the leading one, zero-padded if fewer exist, truncated.
  - Go to OUT.
- OUT: valid_o=1 with stable outputs. Hold until ready_i, then go to IDLE and drop valid_o the next cycle. ready_o=0 in every state except IDLE.
- Latency, accept edge to valid_o: LOG_BITS+2 cycles for normal operands, 1 cycle for special cases. No new operand is accepted while a result is held.
- valid_i is ignored outside IDLE. Operand inputs may change after acceptance.

Optional Feature:
- FLOG_RNE_EN defined: NORM rounds f to nearest-even using guard/sticky bits of mag.
  - Mantissa overflow increments e.
  - If e reaches EMAX, the result is ±inf.
  - Adds no latency.
- Undefined: truncation as above.

Decomposition:
- Package flog_pkg gets:
  - EXP_WIDTH/FRACT_WIDTH/LOG_BITS/MANT_PREC defaults and the BIAS function
  - state enum typedef (IDLE, ITER, NORM, OUT)
  - flag bit index constants
  - canonical NaN/inf constant functions
- One sub-module, flog_mant_iter: owns m, the counter and the log fraction shift register, with start/done ports.
- Classification, NORM and the FSM stay in flog_bf_core.

Test Plan (defaults, bf16 hex {s,e,f}):
- 0x4000 (2.0), ready_i=1 -> 0x3F80 (1.0), flags 0, valid_o exactly 14 cycles after accept.
- 0x3F80 (1.0) -> 0x0000. 0x3F00 (0.5) -> 0xBF80 (-1.0). 0x4100 (8.0) -> 0x4040 (3.0).
- 0x3FC0 (1.5) -> 0x3F15 in truncate build.
- 0x0000 -> 0xFF80, flags=2'b10, valid_o 1 cycle after accept. 0xBF80 -> 0x7FC0, flags=2'b01. 0x7F80 -> 0x7F80.
- Backpressure: ready_i=0 for 5 cycles after valid_o. Outputs stay stable and ready_o stays 0; a second valid_i is not taken until the cycle after the result handshake.
- rst pulsed low asynchronously mid-ITER -> outputs zero immediately, ready_o=1. A following 0x4000 yields 0x3F80 with normal latency.
